instr_trace_arbiter: RTL and testbench
======================================

Name: instr_trace_arbiter

Overview:
- Shares one trace-record sink (log writer / DPI channel) among num_req_p vanilla-core trace sources.
- Each source presents at most one retired-instruction record (pc, instr) per cycle and cannot be stalled, so the block:
  - buffers one record per source;
  - round-robins the buffered records onto a single registered valid/yumi output tagged with the source id;
  - counts records it had to drop.

Parameters:
- num_req_p, 4, number of trace sources (>=2).
- pc_width_p, 32, PC field width.
- instr_width_p, 32, instruction field width.
- drop_cnt_width_p, 16, width of each per-source saturating drop counter.
- id_width_lp, `BSG_SAFE_CLOG2(num_req_p)`, localparam, source-id width.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous reset, active-low
- trace_en_i  in  1  global capture enable
- clear_stats_i  in  1  synchronous clear of drop counters and overflow flags
- req_v_i  in  num_req_p  per-source record valid
- req_pc_i  in  num_req_p*pc_width_p  per-source PC; source k at bits [k*pc_width_p +: pc_width_p]
- req_instr_i  in  num_req_p*instr_width_p  per-source instruction word, same packing
- out_v_o  out  1  output record valid
- out_id_o  out  id_width_lp  source index of output record
- out_pc_o  out  pc_width_p  output PC
- out_instr_o  out  instr_width_p  output instruction
- out_yumi_i  in  1  sink consumes output record this cycle; legal only when out_v_o=1
- drop_count_o  out  num_req_p*drop_cnt_width_p  per-source drop counts
- overflow_o  out  num_req_p  sticky per-source "at least one drop" flag

Behaviour:

Reset (reset_n_i low, asynchronous):
- All slot-full bits = 0.
- out_v_o = 0; out_id_o/out_pc_o/out_instr_o = 0.
- Round-robin pointer = 0.
- drop_count_o = 0; overflow_o = 0.
- Reset asserted mid-operation discards all buffered and output records. No drop is counted for them.

Slots:
- One slot per source: full bit + pc + instr.
- Capture: in cycle t, if trace_en_i=1 and req_v_i[k]=1, the record is written to slot k at the end of t when either:
  - slot k is empty, or
  - slot k is being moved to the output register in cycle t.
- Otherwise the record is dropped, drop_count[k] increments (saturating at all-ones), and overflow[k] is set.
- trace_en_i=0: req_v_i ignored. Nothing is captured and nothing is counted as a drop. Full slots and the output register keep draining normally.

Output register (valid/yumi):
- out_* is registered. It loads when out_v_o=0 or out_yumi_i=1.
- Winner selection: the first full slot at or after the pointer, in increasing index with wrap-around from num_req_p-1 to 0.
- On load with a winner:
  - out_v_o=1; id/pc/instr take the winner's values;
  - the winner's slot is cleared, unless a new capture for it occurs in the same cycle;
  - pointer = (winner+1) mod num_req_p.
- On load with no full slot: out_v_o=0, payload unchanged, pointer unchanged.
- While out_v_o=1 and out_yumi_i=0, all out_* fields hold stable.

Latency and throughput:
- Record at input in cycle t into an empty slot with an idle output appears on out_v_o in cycle t+2.
- Sustained throughput: 1 record/cycle under continuous yumi.

Counters:
- clear_stats_i=1 zeroes all drop counters and overflow flags at the end of the cycle.
- If a drop coincides with clear, clear wins: the result is 0 and the flag is clear.

Order and fairness:
- Per-source order is preserved.
- No source waits more than num_req_p output transfers once its slot is full.

Test Plan:
- Reset with out_yumi_i=1: single req_v_i[2] at cycle 5, pc=0x100, instr=0x00000013 -> out_v_o=1 in cycle 7, out_id_o=2, pc=0x100, instr=0x13. drop_count all 0.
- All 4 sources valid in one cycle, yumi held 1 -> out_id_o sequence 0,1,2,3 on consecutive cycles. Next burst also starts at 0, because the pointer wrapped to 0.
- out_yumi_i=0 for 10 cycles while source 1 pulses valid every cycle:
  - first capture goes to the output register; second fills slot 1; remaining 8 are dropped;
  - drop_count[1]=8, overflow_o[1]=1;
  - out_* stable for all 10 cycles.
- With yumi=1 continuously, source 0 valid every cycle alone -> zero drops, since the slot drains and is refilled in the same cycle. Output sequence matches input pc order.
- trace_en_i=0 while sources toggle valid -> no output, drop counts unchanged. Records already buffered still drain.
- Force drop_count[3] to saturate (2^16 drops) -> stays 0xFFFF. Assert clear_stats_i in the same cycle as a drop -> count 0, overflow_o[3]=0.
- Assert reset_n_i low mid-stream with out_v_o=1 -> out_v_o=0 immediately (asynchronous). After release, the pointer is 0 and all counts are 0.

Source files
------------

// File: rtl/instr_trace_arbiter.sv
// -----------------------------------------------------------------------------
// instr_trace_arbiter
//
// Purpose:
//   Shares one trace-record sink among num_req_p trace sources that cannot be
//   stalled. Each source owns a one-record slot. Full slots are round-robined
//   into a single registered output that the sink consumes with a yumi
//   handshake. A record that arrives while its slot is still occupied (and not
//   being drained that same cycle) is dropped and counted.
//
// Handshake:
//   out_v_o/out_yumi_i is a valid/yumi pair. The output register holds its
//   record stable while out_v_o=1 and out_yumi_i=0. It reloads when it is
//   empty (out_v_o=0) or when its record is consumed (out_yumi_i=1) in the
//   same cycle. out_yumi_i is only meaningful while out_v_o=1.
//
// Ports:
//   clk_i          clock
//   reset_n_i      asynchronous active-low reset
//   trace_en_i     global capture enable (0: inputs ignored, buffers drain)
//   clear_stats_i  synchronous clear of drop counters and overflow flags
//   req_v_i        per-source record valid
//   req_pc_i       per-source PC, source k at [k*pc_width_p +: pc_width_p]
//   req_instr_i    per-source instruction, same packing
//   out_v_o        output record valid
//   out_id_o       source index of the output record
//   out_pc_o       output PC
//   out_instr_o    output instruction
//   out_yumi_i     sink consumes the output record this cycle
//   drop_count_o   per-source saturating drop counters, packed like req_pc_i
//   overflow_o     sticky per-source "at least one drop" flags
// -----------------------------------------------------------------------------
module instr_trace_arbiter #(
    parameter int num_req_p        = 4,
    parameter int pc_width_p       = 32,
    parameter int instr_width_p    = 32,
    parameter int drop_cnt_width_p = 16,
    localparam int id_width_lp     = (num_req_p <= 1) ? 1 : $clog2(num_req_p)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   trace_en_i,
    input  logic                                   clear_stats_i,
    input  logic [num_req_p-1:0]                   req_v_i,
    input  logic [num_req_p*pc_width_p-1:0]        req_pc_i,
    input  logic [num_req_p*instr_width_p-1:0]     req_instr_i,
    output logic                                   out_v_o,
    output logic [id_width_lp-1:0]                 out_id_o,
    output logic [pc_width_p-1:0]                  out_pc_o,
    output logic [instr_width_p-1:0]               out_instr_o,
    input  logic                                   out_yumi_i,
    output logic [num_req_p*drop_cnt_width_p-1:0]  drop_count_o,
    output logic [num_req_p-1:0]                   overflow_o
);

    localparam logic [id_width_lp:0]   num_req_ext_lp = (id_width_lp+1)'(num_req_p);
    localparam logic [id_width_lp-1:0] last_idx_lp    = id_width_lp'(num_req_p - 1);

    // Per-source slots
    logic [num_req_p-1:0]          r_full;
    logic [pc_width_p-1:0]         r_slot_pc    [num_req_p];
    logic [instr_width_p-1:0]      r_slot_instr [num_req_p];

    // Output register and round-robin pointer
    logic                          r_out_v;
    logic [id_width_lp-1:0]        r_out_id;
    logic [pc_width_p-1:0]         r_out_pc;
    logic [instr_width_p-1:0]      r_out_instr;
    logic [id_width_lp-1:0]        r_ptr;

    // Statistics
    logic [drop_cnt_width_p-1:0]   r_drop_cnt [num_req_p];
    logic [num_req_p-1:0]          r_overflow;

    // Combinational control
    logic                          w_load;
    logic                          w_win_found;
    logic [id_width_lp-1:0]        w_win_idx;
    logic [id_width_lp:0]          w_idx_ext;
    logic [id_width_lp-1:0]        w_next_ptr;
    logic [num_req_p-1:0]          w_move;
    logic [num_req_p-1:0]          w_cap;
    logic [num_req_p-1:0]          w_drop;

    assign w_load = ~r_out_v | out_yumi_i;

    // Winner search: scan offsets 0..num_req_p-1 from the pointer and keep the
    // first full slot. r_ptr < num_req_p, so one conditional subtract wraps.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_idx_ext   = '0;
        for (int i = 0; i < num_req_p; i++) begin
            w_idx_ext = {1'b0, r_ptr} + (id_width_lp+1)'(i);
            if (w_idx_ext >= num_req_ext_lp) begin
                w_idx_ext = w_idx_ext - num_req_ext_lp;
            end
            if (!w_win_found && r_full[w_idx_ext[id_width_lp-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_idx_ext[id_width_lp-1:0];
            end
        end
    end

    assign w_next_ptr = (w_win_idx == last_idx_lp) ? '0 : w_win_idx + 1'b1;

    // A slot accepts a new record if it is empty or is being moved to the
    // output register in this very cycle; otherwise the record is lost.
    always_comb begin
        w_move = '0;
        w_cap  = '0;
        w_drop = '0;
        for (int k = 0; k < num_req_p; k++) begin
            w_move[k] = w_load & w_win_found & (w_win_idx == id_width_lp'(k));
            w_cap[k]  = trace_en_i & req_v_i[k] & (~r_full[k] | w_move[k]);
            w_drop[k] = trace_en_i & req_v_i[k] & ~w_cap[k];
        end
    end

    // Slots: a same-cycle capture takes priority over the clear caused by a move.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_full <= '0;
            for (int k = 0; k < num_req_p; k++) begin
                r_slot_pc[k]    <= '0;
                r_slot_instr[k] <= '0;
            end
        end else begin
            for (int k = 0; k < num_req_p; k++) begin
                if (w_cap[k]) begin
                    r_full[k]       <= 1'b1;
                    r_slot_pc[k]    <= req_pc_i[k*pc_width_p +: pc_width_p];
                    r_slot_instr[k] <= req_instr_i[k*instr_width_p +: instr_width_p];
                end else if (w_move[k]) begin
                    r_full[k]       <= 1'b0;
                end
            end
        end
    end

    // Output register: payload and pointer only change when a winner loads.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_out_v     <= 1'b0;
            r_out_id    <= '0;
            r_out_pc    <= '0;
            r_out_instr <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            r_out_v <= w_win_found;
            if (w_win_found) begin
                r_out_id    <= w_win_idx;
                r_out_pc    <= r_slot_pc[w_win_idx];
                r_out_instr <= r_slot_instr[w_win_idx];
                r_ptr       <= w_next_ptr;
            end
        end
    end

    // Drop statistics: clear beats a coincident drop.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_overflow <= '0;
            for (int k = 0; k < num_req_p; k++) begin
                r_drop_cnt[k] <= '0;
            end
        end else if (clear_stats_i) begin
            r_overflow <= '0;
            for (int k = 0; k < num_req_p; k++) begin
                r_drop_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < num_req_p; k++) begin
                if (w_drop[k]) begin
                    r_overflow[k] <= 1'b1;
                    if (r_drop_cnt[k] != '1) begin
                        r_drop_cnt[k] <= r_drop_cnt[k] + 1'b1;
                    end
                end
            end
        end
    end

    assign out_v_o     = r_out_v;
    assign out_id_o    = r_out_id;
    assign out_pc_o    = r_out_pc;
    assign out_instr_o = r_out_instr;
    assign overflow_o  = r_overflow;

    for (genvar k = 0; k < num_req_p; k++) begin : g_drop_out
        assign drop_count_o[k*drop_cnt_width_p +: drop_cnt_width_p] = r_drop_cnt[k];
    end

endmodule

// File: tb/tb_instr_trace_arbiter.sv
// -----------------------------------------------------------------------------
// tb_instr_trace_arbiter
//
// Directed stimulus with a scoreboard: every record the sink should see is
// pushed to exp_q when its source is driven, and popped/compared by a monitor
// on the falling edge whenever the DUT offers a record that is being consumed.
// Inputs change 1 time unit after the rising edge; direct checks are made at
// that same point, after the DUT outputs have settled.
// -----------------------------------------------------------------------------
module tb_instr_trace_arbiter;

    localparam int N     = 4;
    localparam int PCW   = 32;
    localparam int IW    = 32;
    localparam int DW    = 16;
    localparam int IDW   = 2;
    localparam int REC_W = IDW + PCW + IW;

    // Clock/reset and DUT signals
    logic                clk_i = 1'b0;
    logic                reset_n_i;
    logic                trace_en_i;
    logic                clear_stats_i;
    logic [N-1:0]        req_v_i;
    logic [N*PCW-1:0]    req_pc_i;
    logic [N*IW-1:0]     req_instr_i;
    logic                out_v_o;
    logic [IDW-1:0]      out_id_o;
    logic [PCW-1:0]      out_pc_o;
    logic [IW-1:0]       out_instr_o;
    logic                out_yumi_i;
    logic [N*DW-1:0]     drop_count_o;
    logic [N-1:0]        overflow_o;

    always #5 clk_i = ~clk_i;

    instr_trace_arbiter #(
        .num_req_p        (N),
        .pc_width_p       (PCW),
        .instr_width_p    (IW),
        .drop_cnt_width_p (DW)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .trace_en_i    (trace_en_i),
        .clear_stats_i (clear_stats_i),
        .req_v_i       (req_v_i),
        .req_pc_i      (req_pc_i),
        .req_instr_i   (req_instr_i),
        .out_v_o       (out_v_o),
        .out_id_o      (out_id_o),
        .out_pc_o      (out_pc_o),
        .out_instr_o   (out_instr_o),
        .out_yumi_i    (out_yumi_i),
        .drop_count_o  (drop_count_o),
        .overflow_o    (overflow_o)
    );

    // Scoreboard state
    int               errors = 0;
    int               checks = 0;
    logic [REC_W-1:0] exp_q[$];
    logic [REC_W-1:0] mon_rec;
    int               exp_ptr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: a record is transferred when out_v_o and out_yumi_i are both high.
    initial begin
        forever begin
            @(negedge clk_i);
            if (reset_n_i === 1'b1 && out_v_o === 1'b1 && out_yumi_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    mon_rec = exp_q.pop_front();
                    check("out_id",    64'(out_id_o),    64'(mon_rec[REC_W-1 -: IDW]));
                    check("out_pc",    64'(out_pc_o),    64'(mon_rec[PCW+IW-1 -: PCW]));
                    check("out_instr", 64'(out_instr_o), 64'(mon_rec[IW-1:0]));
                    exp_ptr = (int'(mon_rec[REC_W-1 -: IDW]) + 1) % N;
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached with %0d records pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_v_i     = '0;
        req_pc_i    = '0;
        req_instr_i = '0;
    endtask

    task automatic set_src(input int k, input logic [PCW-1:0] pc, input logic [IW-1:0] ins);
        req_v_i[k]               = 1'b1;
        req_pc_i[k*PCW +: PCW]   = pc;
        req_instr_i[k*IW +: IW]  = ins;
    endtask

    task automatic push_exp(input int id, input logic [PCW-1:0] pc, input logic [IW-1:0] ins);
        exp_q.push_back({IDW'(id), pc, ins});
    endtask

    function automatic logic [DW-1:0] get_drop(input int k);
        return drop_count_o[k*DW +: DW];
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
        step();
        check({tag, "_idle"}, 64'(out_v_o), 64'd0);
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        exp_q.delete();
        step();
        step();
        reset_n_i = 1'b1;
        exp_ptr   = 0;
    endtask

    // Main sequence
    initial begin
        logic [IW-1:0] ins;
        int            id;

        reset_n_i     = 1'b0;
        trace_en_i    = 1'b1;
        clear_stats_i = 1'b0;
        out_yumi_i    = 1'b0;
        idle_inputs();
        repeat (3) step();

        // Reset state
        check("rst_out_v",     64'(out_v_o),      64'd0);
        check("rst_out_id",    64'(out_id_o),     64'd0);
        check("rst_out_pc",    64'(out_pc_o),     64'd0);
        check("rst_out_instr", 64'(out_instr_o),  64'd0);
        check("rst_drop",      64'(drop_count_o), 64'd0);
        check("rst_ovf",       64'(overflow_o),   64'd0);
        reset_n_i = 1'b1;

        // T1: single record, two-cycle latency
        out_yumi_i = 1'b1;
        repeat (4) step();
        set_src(2, 32'h100, 32'h0000_0013);
        push_exp(2, 32'h100, 32'h0000_0013);
        step();
        idle_inputs();
        check("t1_lat_t1", 64'(out_v_o), 64'd0);
        step();
        check("t1_lat_t2_v",  64'(out_v_o),     64'd1);
        check("t1_lat_t2_id", 64'(out_id_o),    64'd2);
        check("t1_lat_t2_pc", 64'(out_pc_o),    64'h100);
        check("t1_lat_t2_in", 64'(out_instr_o), 64'h13);
        drain("t1", 10);
        check("t1_drop", 64'(drop_count_o), 64'd0);

        // T2: all sources at once, two bursts, pointer wraps back to 0
        do_reset();
        out_yumi_i = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < N; k++) begin
                ins = $urandom;
                set_src(k, 32'h1000 + 32'(b*16 + k), ins);
                push_exp(k, 32'h1000 + 32'(b*16 + k), ins);
            end
            step();
            idle_inputs();
            check("t2_first_idle", 64'(out_v_o), 64'd0);
            for (int k = 0; k < N; k++) begin
                step();
                check("t2_seq_v",  64'(out_v_o),  64'd1);
                check("t2_seq_id", 64'(out_id_o), 64'(k));
            end
            step();
            check("t2_after_v", 64'(out_v_o), 64'd0);
            repeat (3) step();
            check("t2_q_empty", 64'(exp_q.size()), 64'd0);
        end

        // T3: stalled sink, source 1 every cycle -> 8 drops, output stable
        out_yumi_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_src(1, 32'h200 + 32'(i), 32'hA0 + 32'(i));
            if (i < 2) push_exp(1, 32'h200 + 32'(i), 32'hA0 + 32'(i));
            step();
            if (i >= 1) begin
                check("t3_hold_v",  64'(out_v_o),     64'd1);
                check("t3_hold_id", 64'(out_id_o),    64'd1);
                check("t3_hold_pc", 64'(out_pc_o),    64'h200);
                check("t3_hold_in", 64'(out_instr_o), 64'hA0);
            end
        end
        idle_inputs();
        check("t3_drop1", 64'(get_drop(1)), 64'd8);
        check("t3_drop0", 64'(get_drop(0)), 64'd0);
        check("t3_ovf",   64'(overflow_o),  64'b0010);
        out_yumi_i = 1'b1;
        drain("t3", 10);

        // T4: continuous yumi, source 0 every cycle -> no drops, order kept
        for (int i = 0; i < 20; i++) begin
            ins = $urandom;
            set_src(0, 32'h300 + 32'(i), ins);
            push_exp(0, 32'h300 + 32'(i), ins);
            step();
        end
        idle_inputs();
        drain("t4", 10);
        check("t4_drop0", 64'(get_drop(0)), 64'd0);
        check("t4_ovf",   64'(overflow_o),  64'b0010);

        // T5: buffer four records, then disable capture while inputs toggle
        out_yumi_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            set_src(k, 32'h500 + 32'(k), 32'h5000_0000 + 32'(k));
        end
        for (int j = 0; j < N; j++) begin
            id = (exp_ptr + j) % N;
            push_exp(id, 32'h500 + 32'(id), 32'h5000_0000 + 32'(id));
        end
        step();
        trace_en_i = 1'b0;
        out_yumi_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_v_i     = N'($urandom_range(0, 15));
            req_pc_i    = {$urandom, $urandom, $urandom, $urandom};
            req_instr_i = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        idle_inputs();
        trace_en_i = 1'b1;
        check("t5_q_empty", 64'(exp_q.size()), 64'd0);
        check("t5_out_v",   64'(out_v_o),      64'd0);
        check("t5_drop",    64'(drop_count_o), {16'd0, 16'd0, 16'd8, 16'd0});
        check("t5_ovf",     64'(overflow_o),   64'b0010);

        // T6: saturate source 3, then clear coincident with a drop
        out_yumi_i = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            set_src(3, 32'h400 + 32'(i), 32'h77);
            if (i < 2) push_exp(3, 32'h400 + 32'(i), 32'h77);
            step();
        end
        check("t6_sat",     64'(get_drop(3)), 64'hFFFF);
        check("t6_sat_ovf", 64'(overflow_o),  64'b1010);
        clear_stats_i = 1'b1;
        step();
        clear_stats_i = 1'b0;
        check("t6_clr_drop", 64'(drop_count_o), 64'd0);
        check("t6_clr_ovf",  64'(overflow_o),   64'd0);
        step();
        idle_inputs();
        check("t6_post_drop", 64'(get_drop(3)), 64'd1);
        check("t6_post_ovf",  64'(overflow_o),  64'b1000);
        out_yumi_i = 1'b1;
        drain("t6", 10);

        // T7: asynchronous reset mid-stream
        out_yumi_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            set_src(k, 32'h700 + 32'(k), 32'h7000_0000 + 32'(k));
        end
        step();
        idle_inputs();
        step();
        check("t7_pre_v", 64'(out_v_o), 64'd1);
        #2;
        reset_n_i = 1'b0;
        exp_q.delete();
        #1;
        check("t7_async_v",  64'(out_v_o),  64'd0);
        check("t7_async_pc", 64'(out_pc_o), 64'd0);
        step();
        step();
        reset_n_i = 1'b1;
        exp_ptr   = 0;
        check("t7_drop", 64'(drop_count_o), 64'd0);
        check("t7_ovf",  64'(overflow_o),   64'd0);
        step();
        check("t7_no_stale", 64'(out_v_o), 64'd0);
        out_yumi_i = 1'b1;
        for (int k = 0; k < N; k++) begin
            set_src(k, 32'h800 + 32'(k), 32'h8000_0000 + 32'(k));
            push_exp(k, 32'h800 + 32'(k), 32'h8000_0000 + 32'(k));
        end
        step();
        idle_inputs();
        for (int k = 0; k < N; k++) begin
            step();
            check("t7_seq_id", 64'(out_id_o), 64'(k));
        end
        drain("t7", 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
